// File: rtl/i2c_mux_pkg.sv
// i2c_mux_pkg: shared FSM/direction types and byte framing constants for the I2C channel mux
package i2c_mux_pkg;
  localparam int BITS_PER_BYTE = 8;
  localparam int ACK_BIT = 8;
  typedef enum logic [2:0] {IDLE, ADDR, AACK, WDATA, WACK, RDATA, RACK} state_t;
  typedef enum logic {DIR_DOWN, DIR_UP} dir_t;
  function automatic dir_t state_dir(input state_t s);
    return (s == AACK || s == WACK || s == RDATA) ? DIR_UP : DIR_DOWN;
  endfunction
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronises the upstream SCL/SDA pair and derives edge and START/STOP pulses
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= o_scl;
      r_sda_d    <= o_sda;
    end
  assign o_scl      = r_scl_sync[SYNC_STAGES-1];
  assign o_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_scl_rise = o_scl & ~r_scl_d;
  assign o_scl_fall = ~o_scl & r_scl_d;
  assign o_start    = r_scl_d & o_scl & r_sda_d & ~o_sda;
  assign o_stop     = r_scl_d & o_scl & ~r_sda_d & o_sda;
endmodule

// File: rtl/i2c_mux_nch.sv
// i2c_mux_nch: 1-to-NCH I2C bus mux with an in-band PCA9548-style channel-enable register
module i2c_mux_nch import i2c_mux_pkg::*; #(
  parameter int         NCH         = 4,
  parameter logic [6:0] MUX_ADDR    = 7'h70,
  parameter logic [7:0] RST_MASK    = 8'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic           iClk,
  input  logic           iRstn,
  inout  wire            SCL_m,
  inout  wire            SDA_m,
  inout  wire  [NCH-1:0] SCL_s,
  inout  wire  [NCH-1:0] SDA_s,
  output logic [NCH-1:0] oChEn,
  output logic           oBusy
);
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic [SYNC_STAGES-1:0][NCH-1:0] r_sda_s_sync;
  logic [NCH-1:0] w_sda_s;
  state_t r_state, w_state_nxt;
  dir_t w_dir;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic w_byte_end, w_ack_end, w_self_data, w_mux_low;
  logic [7:0] r_shift, r_tx;
  logic r_rw, r_self;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_scl_s_low, r_sda_s_low, w_sda_s_low_nxt;
  logic r_sda_m_low, w_sda_m_low_nxt;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .iClk(iClk), .iRstn(iRstn), .i_scl(SCL_m), .i_sda(SDA_m),
    .o_scl(w_scl), .o_sda(w_sda), .o_scl_rise(w_rise), .o_scl_fall(w_fall),
    .o_start(w_start), .o_stop(w_stop)
  );

  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) r_sda_s_sync <= '1;
    else r_sda_s_sync <= {r_sda_s_sync[SYNC_STAGES-2:0], SDA_s};
  assign w_sda_s = r_sda_s_sync[SYNC_STAGES-1];

  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end

  // The bit counter runs 1..8 across a byte and reaches 9 on the acknowledge bit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_rise ? r_cnt + 4'd1 : r_cnt;
    w_byte_end  = w_fall && r_cnt == 4'(BITS_PER_BYTE);
    w_ack_end   = w_fall && r_cnt == 4'(ACK_BIT + 1);
    if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = '0;
    end else if (w_stop) w_state_nxt = IDLE;
    else if ((r_state == ADDR || r_state == WDATA || r_state == RDATA) && w_byte_end)
      w_state_nxt = r_state == ADDR ? AACK : r_state == WDATA ? WACK : RACK;
    else if ((r_state == AACK || r_state == WACK || r_state == RACK) && w_ack_end) begin
      w_state_nxt = r_state == AACK ? (r_rw ? RDATA : WDATA) : r_state == WACK ? WDATA : (r_shift[0] ? IDLE : RDATA);
      w_cnt_nxt   = '0;
    end
    w_dir           = state_dir(r_state);
    w_self_data     = r_self && (r_state == WDATA || r_state == WACK || r_state == RDATA || r_state == RACK);
    w_mux_low       = r_self && (r_state == AACK || r_state == WACK || (r_state == RDATA && !r_tx[7]));
    w_sda_s_low_nxt = (w_dir == DIR_DOWN && !w_self_data && !w_sda) ? oChEn : '0;
    w_sda_m_low_nxt = w_dir == DIR_UP && (((|(oChEn & ~w_sda_s)) && !w_self_data) || w_mux_low);
  end

  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) begin
      r_shift     <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_self      <= 1'b0;
      r_pend      <= RST_MASK[NCH-1:0];
      oChEn       <= RST_MASK[NCH-1:0];
      oBusy       <= 1'b0;
      r_scl_s_low <= '0;
      r_sda_s_low <= '0;
      r_sda_m_low <= 1'b0;
    end else begin
      if (w_rise) r_shift <= {r_shift[6:0], w_sda};
      if (w_start || w_stop) r_self <= 1'b0;
      else if (r_state == ADDR && w_byte_end) begin
        r_self <= r_shift[7:1] == MUX_ADDR;
        r_rw   <= r_shift[0];
      end
      if (r_state == WDATA && w_byte_end && r_self) r_pend <= r_shift[NCH-1:0];
      // Committing only on STOP keeps the channel set frozen across repeated STARTs
      if (w_stop) oChEn <= r_pend;
      oBusy <= w_start ? 1'b1 : w_stop ? 1'b0 : oBusy;
      if (w_state_nxt == RDATA && r_state != RDATA) r_tx <= 8'(r_pend);
      else if (r_state == RDATA && w_fall) r_tx <= {r_tx[6:0], 1'b0};
      r_scl_s_low <= w_scl ? '0 : oChEn;
      r_sda_s_low <= w_sda_s_low_nxt;
      r_sda_m_low <= w_sda_m_low_nxt;
    end

  assign SDA_m = r_sda_m_low ? 1'b0 : 1'bz;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign SDA_s[i] = r_sda_s_low[i] ? 1'b0 : 1'bz;
    assign SCL_s[i] = r_scl_s_low[i] ? 1'b0 : 1'bz;
  end
endmodule

// File: tb/tb_i2c_mux_nch.sv
// tb_i2c_mux_nch: bit-banged master and scripted slaves around i2c_mux_nch with a per-bit scoreboard
module tb_i2c_mux_nch;
  localparam int NCH = 4;
  localparam int Q = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic [NCH-1:0] s_low = '0;
  logic [NCH-1:0] m_en = 4'b0001;
  wire scl_m, sda_m;
  wire [NCH-1:0] scl_s, sda_s;
  logic [NCH-1:0] ch_en;
  logic busy;
  int n_chk = 0, n_fail = 0;
  logic [31:0] sb_exp[$];
  string sb_tag[$];

  pullup (scl_m);
  pullup (sda_m);
  pullup (scl_s);
  pullup (sda_s);
  assign scl_m = m_scl ? 1'bz : 1'b0;
  assign sda_m = m_sda ? 1'bz : 1'b0;
  for (genvar g = 0; g < NCH; g++) begin : g_sl
    assign sda_s[g] = s_low[g] ? 1'b0 : 1'bz;
  end

  always #5 clk = ~clk;

  i2c_mux_nch #(.NCH(NCH), .MUX_ADDR(7'h70), .RST_MASK(8'h01), .SYNC_STAGES(2)) dut (
    .iClk(clk), .iRstn(rst_n), .SCL_m(scl_m), .SDA_m(sda_m),
    .SCL_s(scl_s), .SDA_s(sda_s), .oChEn(ch_en), .oBusy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    if (sb_exp.size() == 0) chk("sb_underflow", 32'(sb_exp.size()), 32'd1);
    else chk(sb_tag.pop_front(), act, sb_exp.pop_front());
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Packed observation per bit: {SCL_s during low phase, SDA_s and SDA_m during high phase}
  task automatic bit_x(input string tag, input logic b, input logic [3:0] sl, input logic up,
                       input logic blk, input logic mux_low, output logic rd);
    logic [3:0] es;
    logic em;
    logic [8:0] act;
    es = (up || blk) ? ~sl : ~sl & ~(m_en & {4{~b}});
    em = up ? !(((|(sl & m_en)) && !blk) || mux_low) : b;
    sb_push(tag, 32'({~m_en, es, em}));
    m_sda = b;
    s_low = sl;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    rd = sda_m;
    act[4:0] = {sda_s, sda_m};
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
    act[8:5] = scl_s;
    sb_pop(32'(act));
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] d, input logic blk,
                         input logic [3:0] ack_sl, input logic ack_mux, input logic ack_blk);
    logic rd;
    for (int i = 7; i >= 0; i--) bit_x(tag, d[i], 4'h0, 1'b0, blk, 1'b0, rd);
    bit_x({tag, "_ack"}, 1'b1, ack_sl, 1'b1, ack_blk, ack_mux, rd);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] sdata, input logic [3:0] ch, input logic blk,
                         input logic [7:0] mux_data, input logic mack, output logic [7:0] got);
    logic rd;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_x(tag, 1'b1, sdata[i] ? 4'h0 : ch, 1'b1, blk, blk && !mux_data[i], rd);
      got = {got[6:0], rd};
    end
    bit_x({tag, "_mack"}, mack, 4'h0, 1'b0, blk, 1'b0, rd);
  endtask

  task automatic start_c();
    s_low = '0;
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic stop_c();
    s_low = '0;
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic rd;
    tick(3);
    chk("rst_sda_m", 32'(sda_m), 32'd1);
    chk("rst_scl_m", 32'(scl_m), 32'd1);
    chk("rst_sda_s", 32'(sda_s), 32'hF);
    chk("rst_scl_s", 32'(scl_s), 32'hF);
    chk("rst_chen", 32'(ch_en), 32'h1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(5);
    // Plain write to a channel-0 slave
    start_c();
    chk("busy_start", 32'(busy), 32'd1);
    wr_byte("a50", 8'hA0, 1'b0, 4'b0001, 1'b0, 1'b0);
    wr_byte("d_a5", 8'hA5, 1'b0, 4'b0001, 1'b0, 1'b0);
    stop_c();
    chk("busy_stop", 32'(busy), 32'd0);
    chk("chen_wr50", 32'(ch_en), 32'h1);
    // Program mask 0x0A; commit only at STOP
    start_c();
    wr_byte("a70", 8'hE0, 1'b0, 4'h0, 1'b1, 1'b0);
    wr_byte("d0a", 8'h0A, 1'b1, 4'h0, 1'b1, 1'b1);
    chk("chen_pre_stop", 32'(ch_en), 32'h1);
    stop_c();
    m_en = 4'hA;
    chk("chen_commit_a", 32'(ch_en), 32'hA);
    // Channels 1 and 3 only; ACKs from disabled channels must not reach the master
    start_c();
    wr_byte("a50_ch13", 8'hA0, 1'b0, 4'b1010, 1'b0, 1'b0);
    wr_byte("d3c_dis", 8'h3C, 1'b0, 4'b0101, 1'b0, 1'b0);
    stop_c();
    // Read the mask back from the mux itself
    start_c();
    wr_byte("a70r", 8'hE1, 1'b0, 4'h0, 1'b1, 1'b0);
    rd_byte("rd_self", 8'hFF, 4'h0, 1'b1, 8'h0A, 1'b1, got);
    chk("rd_self_byte", 32'(got), 32'h0A);
    stop_c();
    // Repeated START must not commit the pending mask
    start_c();
    wr_byte("a70w", 8'hE0, 1'b0, 4'h0, 1'b1, 1'b0);
    wr_byte("d04", 8'h04, 1'b1, 4'h0, 1'b1, 1'b1);
    start_c();
    chk("chen_rstart", 32'(ch_en), 32'hA);
    wr_byte("a50_rs", 8'hA0, 1'b0, 4'b0010, 1'b0, 1'b0);
    stop_c();
    m_en = 4'h4;
    chk("chen_commit_4", 32'(ch_en), 32'h4);
    // Two-byte read from a channel-2 slave
    start_c();
    wr_byte("a50r", 8'hA1, 1'b0, 4'b0100, 1'b0, 1'b0);
    rd_byte("rd1", 8'h96, 4'b0100, 1'b0, 8'h00, 1'b0, got);
    chk("rd1_byte", 32'(got), 32'h96);
    rd_byte("rd2", 8'h3B, 4'b0100, 1'b0, 8'h00, 1'b1, got);
    chk("rd2_byte", 32'(got), 32'h3B);
    stop_c();
    chk("idle_sda_m", 32'(sda_m), 32'd1);
    chk("idle_sda_s", 32'(sda_s), 32'hF);
    chk("idle_scl_s", 32'(scl_s), 32'hF);
    chk("idle_busy", 32'(busy), 32'd0);
    // Enable all channels, leave a pending mask, then reset mid-byte
    start_c();
    wr_byte("a70f", 8'hE0, 1'b0, 4'h0, 1'b1, 1'b0);
    wr_byte("d0f", 8'h0F, 1'b1, 4'h0, 1'b1, 1'b1);
    stop_c();
    m_en = 4'hF;
    chk("chen_commit_f", 32'(ch_en), 32'hF);
    start_c();
    wr_byte("a70p", 8'hE0, 1'b0, 4'h0, 1'b1, 1'b0);
    wr_byte("d02", 8'h02, 1'b1, 4'h0, 1'b1, 1'b1);
    start_c();
    bit_x("a50_b7", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, rd);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    chk("pre_rst_sda_s", 32'(sda_s), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sda_s", 32'(sda_s), 32'hF);
    chk("rst_async_chen", 32'(ch_en), 32'h1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    m_en = 4'h1;
    @(negedge clk);
    m_sda = 1'b1;
    tick(Q);
    rst_n = 1'b1;
    tick(Q);
    start_c();
    stop_c();
    chk("chen_pend_discard", 32'(ch_en), 32'h1);
    chk("end_sda_s", 32'(sda_s), 32'hF);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
